// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit 7-segment scan driver: hex decode, leading-zero
// suppression, per-digit blank/DP, brightness PWM with anti-ghost dead time.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CPD          = 25000,
    parameter int GHOST_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_value,
    input  logic [NUM_DIGITS-1:0]   i_dp_mask,
    input  logic [NUM_DIGITS-1:0]   i_blank_mask,
    input  logic                    i_lz_en,
    input  logic [3:0]              i_brightness,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame_tick
);

    localparam int CW = $clog2(CPD);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = CW + 5;
    localparam logic [CW-1:0] CNT_MAX = CW'(CPD - 1);
    localparam logic [DW-1:0] D_MAX   = DW'(NUM_DIGITS - 1);
    localparam logic          INV     = (ACTIVE_LOW != 0);

    logic [CW-1:0]           r_cnt;
    logic [DW-1:0]           r_d;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_dp_mask;
    logic [NUM_DIGITS-1:0]   r_blank_mask;
    logic                    r_lz_en;
    logic [3:0]              r_brightness;

    logic                    w_frame_start;
    logic [4*NUM_DIGITS-1:0] w_value;
    logic [NUM_DIGITS-1:0]   w_dp_mask;
    logic [NUM_DIGITS-1:0]   w_blank_mask;
    logic                    w_lz_en;
    logic [3:0]              w_brightness;
    logic [3:0]              w_nib;
    logic [6:0]              w_dec;
    logic                    w_upper_zero;
    logic                    w_blank;
    logic [PW-1:0]           w_prod;
    logic [PW-1:0]           w_on_lim;
    logic                    w_on;
    logic [NUM_DIGITS-1:0]   w_an_h;
    logic [6:0]              w_seg_h;
    logic                    w_dp_h;

    assign w_frame_start = (r_cnt == '0) && (r_d == D_MAX);

    // The frame-start cycle already decodes from the freshly sampled inputs,
    // so new values reach the pins on the very next cycle.
    assign w_value      = w_frame_start ? i_value      : r_value;
    assign w_dp_mask    = w_frame_start ? i_dp_mask    : r_dp_mask;
    assign w_blank_mask = w_frame_start ? i_blank_mask : r_blank_mask;
    assign w_lz_en      = w_frame_start ? i_lz_en      : r_lz_en;
    assign w_brightness = w_frame_start ? i_brightness : r_brightness;

    assign w_nib = w_value[4*r_d +: 4];

    always_comb begin
        w_dec = 7'h00;
        case (w_nib)
            4'h0: w_dec = 7'h3F;
            4'h1: w_dec = 7'h06;
            4'h2: w_dec = 7'h5B;
            4'h3: w_dec = 7'h4F;
            4'h4: w_dec = 7'h66;
            4'h5: w_dec = 7'h6D;
            4'h6: w_dec = 7'h7D;
            4'h7: w_dec = 7'h07;
            4'h8: w_dec = 7'h7F;
            4'h9: w_dec = 7'h6F;
            4'hA: w_dec = 7'h77;
            4'hB: w_dec = 7'h7C;
            4'hC: w_dec = 7'h39;
            4'hD: w_dec = 7'h5E;
            4'hE: w_dec = 7'h79;
            4'hF: w_dec = 7'h71;
            default: w_dec = 7'h00;
        endcase
    end

    always_comb begin
        w_upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((i >= int'(r_d)) && (w_value[4*i +: 4] != 4'd0))
                w_upper_zero = 1'b0;
        end
    end

    assign w_blank = w_blank_mask[r_d] | (w_lz_en & (r_d != '0) & w_upper_zero);

    // Widened product so brightness 15 lands exactly on CPD without overflow.
    assign w_prod   = (PW'(w_brightness) + PW'(1)) * PW'(CPD - GHOST_CYCLES);
    assign w_on_lim = PW'(GHOST_CYCLES) + (w_prod >> 4);
    assign w_on     = (PW'(r_cnt) >= PW'(GHOST_CYCLES)) && (PW'(r_cnt) < w_on_lim) && !w_blank;

    always_comb begin
        w_an_h = '0;
        if (w_on)
            w_an_h[r_d] = 1'b1;
    end

    assign w_seg_h = w_on ? w_dec : 7'h00;
    assign w_dp_h  = w_on & w_dp_mask[r_d];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt        <= '0;
            r_d          <= D_MAX;
            r_value      <= '0;
            r_dp_mask    <= '0;
            r_blank_mask <= '0;
            r_lz_en      <= 1'b0;
            r_brightness <= 4'd0;
            o_an         <= {NUM_DIGITS{INV}};
            o_seg        <= {7{INV}};
            o_dp         <= INV;
            o_frame_tick <= 1'b0;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_d   <= (r_d == '0) ? D_MAX : r_d - DW'(1);
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_frame_start) begin
                r_value      <= i_value;
                r_dp_mask    <= i_dp_mask;
                r_blank_mask <= i_blank_mask;
                r_lz_en      <= i_lz_en;
                r_brightness <= i_brightness;
            end
            o_an         <= w_an_h ^ {NUM_DIGITS{INV}};
            o_seg        <= w_seg_h ^ {7{INV}};
            o_dp         <= w_dp_h ^ INV;
            o_frame_tick <= w_frame_start;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: expected pin frames are queued
// before each frame is scanned and popped one per cycle on the falling edge.
module tb_seven_seg_scan_driver;

    localparam int ND  = 4;
    localparam int CPD = 20;
    localparam int GH  = 2;
    localparam int FRAME = ND * CPD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    int checks = 0;
    int errors = 0;

    // {an, seg, dp, frame_tick}
    logic [12:0] exp_q[$];

    seven_seg_scan_driver #(
        .NUM_DIGITS(ND), .CPD(CPD), .GHOST_CYCLES(GH), .ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_value(value), .i_dp_mask(dp_mask),
        .i_blank_mask(blank_mask), .i_lz_en(lz_en), .i_brightness(brightness),
        .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed an=%b seg=%h dp=%b tick=%b, expected an=%b seg=%h dp=%b tick=%b",
                   tag, obs[12:9], obs[8:2], obs[1], obs[0], expv[12:9], expv[8:2], expv[1], expv[0]);
        end
    endtask

    function automatic logic [12:0] pins();
        return {an, seg, dp, frame_tick};
    endfunction

    // Advances at least one cycle, then waits (bounded) for frame_tick.
    task automatic wait_tick(input string tag);
        int n = 0;
        @(negedge clk);
        while (!frame_tick && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (frame_tick === 1'b1) else begin
            errors++;
            $error("FAIL %s: frame_tick not seen within %0d cycles (observed %b, expected 1)", tag, 3 * FRAME, frame_tick);
        end
    endtask

    // Called on the negedge where frame_tick is expected high. segs holds the
    // active-low segment pins per digit; lit marks digits that light at all.
    task automatic run_frame(input string tag, input logic [6:0] segs [4], input logic [3:0] lit,
                             input logic [3:0] dpm, input int on_lim,
                             input int chg_k, input logic [15:0] chg_v);
        logic [12:0] e;
        logic [12:0] o;
        for (int k = 0; k < FRAME; k++) begin
            int d = ND - 1 - k / CPD;
            int c = k % CPD;
            logic act = lit[d] && (c >= GH) && (c < on_lim);
            logic [3:0] an_e = 4'hF;
            if (act) an_e[d] = 1'b0;
            e = {an_e, act ? segs[d] : 7'h7F, !(act && dpm[d]), (k == 0)};
            exp_q.push_back(e);
        end
        for (int k = 0; k < FRAME; k++) begin
            if (k == chg_k) value = chg_v;
            o = pins();
            e = exp_q.pop_front();
            check($sformatf("%s k=%0d", tag, k), o, e);
            @(negedge clk);
        end
    endtask

    logic [6:0] s [4];

    initial begin
        rst = 1'b1; value = 16'h1A2F; dp_mask = 4'b0000; blank_mask = 4'b0000;
        lz_en = 1'b0; brightness = 4'd15;
        repeat (3) @(negedge clk);
        check("reset", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});

        rst = 1'b0;
        @(negedge clk);
        // Hex decode: 1 A 2 F at full brightness, first frame right after reset.
        s = '{7'h0E, 7'h24, 7'h08, 7'h79};
        run_frame("hex", s, 4'b1111, 4'b0000, CPD, -1, 16'h0);
        // Loop ended on the next frame's tick cycle: verifies the 80-cycle period.
        run_frame("hex2", s, 4'b1111, 4'b0000, CPD, -1, 16'h0);

        value = 16'h0050; lz_en = 1'b1;
        wait_tick("lz_sync");
        s = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        run_frame("lz", s, 4'b0011, 4'b0000, CPD, -1, 16'h0);

        value = 16'h0000;
        wait_tick("lz0_sync");
        s = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        run_frame("lz_zero", s, 4'b0001, 4'b0000, CPD, -1, 16'h0);

        value = 16'h1A2F; lz_en = 1'b0; brightness = 4'd3; dp_mask = 4'b0100;
        wait_tick("bri_sync");
        s = '{7'h0E, 7'h24, 7'h08, 7'h79};
        run_frame("bright_dp", s, 4'b1111, 4'b0100, 6, -1, 16'h0);

        brightness = 4'd15; dp_mask = 4'b1001; blank_mask = 4'b0010;
        wait_tick("blank_sync");
        run_frame("blank", s, 4'b1101, 4'b1001, CPD, -1, 16'h0);

        dp_mask = 4'b0000; blank_mask = 4'b0000; value = 16'h1234;
        wait_tick("tear_sync");
        s = '{7'h19, 7'h30, 7'h24, 7'h79};
        run_frame("tear_a", s, 4'b1111, 4'b0000, CPD, 25, 16'h5678);
        s = '{7'h00, 7'h78, 7'h02, 7'h12};
        run_frame("tear_b", s, 4'b1111, 4'b0000, CPD, -1, 16'h0);

        // Mid-frame reset in digit 1's slot; current negedge is frame cycle 0.
        repeat (45) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out", pins(), {4'hF, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0;
        @(negedge clk);
        run_frame("after_rst", s, 4'b1111, 4'b0000, CPD, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
